fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of `instruction_memory_bram`. It owns the program counter and drives the BRAM address. It absorbs the BRAM's one-cycle registered-read latency and delivers (instruction, PC) pairs to the decode stage over a valid/ready handshake. A 2-entry output buffer lets a decode stall hold instructions without loss, and a redirect port (branch/jump) flushes the stage and restarts fetch at a new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] treated as 0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` out 32: byte address to `instruction_memory_bram`; equals the PC register (driven from a register, no combinational path from inputs).
- `imem_data` in 32: BRAM read data; valid in the cycle after the address was sampled at a rising edge.
- `redirect_valid` in 1: restart fetch at `redirect_pc`; single-cycle pulse.
- `redirect_pc` in 32: new fetch address; bits [1:0] forced to 0.
- `inst_valid` out 1: buffer head holds a valid instruction.
- `inst` out 32: instruction word at buffer head.
- `inst_pc` out 32: byte address `inst` was fetched from.
- `inst_ready` in 1: decode accepts head this cycle; transfer occurs when `inst_valid && inst_ready`.

## Operation
- State:
  - `pc` (32): next address to issue.
  - `inflight` (1) and `inflight_pc` (32): request awaiting BRAM data.
  - 2-entry FIFO of {inst, pc} with `count` 0..2.
- Pop: `pop = inst_valid && inst_ready`.
- Issue condition: `issue = !redirect_valid && (count + inflight - pop) <= 1`. This guarantees a slot for every in-flight response.
- On issue: at the edge, `inflight<=1`, `inflight_pc<=pc`, `pc<=pc+4` (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Without issue: `pc` holds and `inflight<=0`. The BRAM still reads `imem_addr` every cycle, but unissued data is ignored.
- Response: when `inflight==1`, {`imem_data`, `inflight_pc`} is pushed into the FIFO at the end of that cycle.
  - Simultaneous push and pop is allowed.
  - Push into a full FIFO cannot occur, because the issue rule prevents it. Assert this in simulation.
- Head outputs (`inst`, `inst_pc`) are taken from the FIFO head register. They stay stable while `inst_valid && !inst_ready`.
- Redirect, which has priority over everything except reset:
  - At the edge, `count<=0` and `inflight<=0`; any response arriving this cycle is discarded.
  - `pc<=redirect_pc & ~3`.
  - A pop in the same cycle is treated as consumed and is harmless.
- Reset:
  - Outputs: `pc<=RESET_PC`, `imem_addr=RESET_PC`, `inflight=0`, `count=0`, `inst_valid=0`, `inst=0`, `inst_pc=0`.
  - Reset mid-operation discards the FIFO and in-flight data; `redirect_valid` is ignored while `reset=1`.
- No states beyond the above; the buffer is the only "FSM".
  - EMPTY (`count` 0), ONE (`count` 1), FULL (`count` 2).
  - Transitions driven by push/pop; redirect or reset force EMPTY.

## Timing
- Reset released before edge E0: issue of `RESET_PC` in cycle after E0 (C1); data in C2; `inst_valid=1` in C3 with `inst_pc=RESET_PC`.
- Fetch-to-valid latency: 2 cycles from issue cycle.
- Redirect-to-valid latency: 3 cycles.
  - Redirect in cycle R; issue of target in R+1; `inst_valid` with `inst_pc=redirect_pc` in R+3.
  - `inst_valid` is 0 in R+1 and R+2.
- Throughput with `inst_ready` held high: one instruction per cycle after the initial latency. Steady state is `count`=1, `inflight`=1.
- Stall: drop `inst_ready` and the FIFO fills to 2 within 1 cycle. Issue stops; `imem_addr` holds the next unissued PC.
- Release `inst_ready`: consecutive pops are gap-free. Refill maintains 1/cycle without bubbles.

## Test plan
BRAM model holds word 32'hA000_0000+(addr>>2) at each address.
- Reset, `inst_ready`=1 -> `inst_valid` first high 2 cycles after the first issue cycle.
  - `inst`/`inst_pc` = A000_0000/0, A000_0001/4, A000_0002/8 on consecutive cycles, no bubbles.
- Hold `inst_ready`=0 from the 2nd valid cycle for 5 cycles, then release -> `count` saturates at 2.
  - `inst` holds A000_0001 throughout the stall.
  - After release, A000_0001, A000_0002, A000_0003 on consecutive cycles; no PC skipped or duplicated.
- Redirect pulse with `redirect_pc`=32'h0000_0043 while the FIFO holds 2 entries -> the next valid has `inst_pc`=32'h40, `inst`=A000_0010, 3 cycles after the pulse.
  - No stale instruction appears in between.
- Redirect in the same cycle as an in-flight response and a pop -> the response is discarded; the only subsequent valids come from the redirect target.
- `RESET_PC`=32'hFFFF_FFF8, `inst_ready`=1 -> `inst_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert `reset` for 1 cycle mid-stream with the FIFO full -> `inst_valid`=0 in the cycle after reset.
  - Fetch restarts at `RESET_PC` with the same 2-cycle latency; no pre-reset instruction is delivered.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of instruction_memory_bram. Owns the
// program counter, drives the BRAM address straight from the PC register,
// absorbs the BRAM's one-cycle registered-read latency and hands
// (instruction, PC) pairs to decode over a valid/ready handshake. A 2-entry
// output buffer absorbs decode stalls; a redirect flushes the stage and
// restarts fetch at a new PC.
//
// Parameters
//   RESET_PC        PC loaded on reset (bits [1:0] ignored)
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous, active-high
//   imem_addr       byte address to the BRAM (registered PC)
//   imem_data       BRAM read data for the address sampled at the last edge
//   redirect_valid  single-cycle pulse: flush and restart at redirect_pc
//   redirect_pc     new fetch address (bits [1:0] forced to 0)
//   inst_valid      buffer head holds a valid instruction
//   inst            instruction word at the buffer head
//   inst_pc         byte address inst was fetched from
//   inst_ready      decode accepts the head this cycle
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  // Output buffer occupancy; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  buf_state_e  buf_state_q, buf_state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;

  logic [31:0] entry_inst_q [2];
  logic [31:0] entry_pc_q   [2];

  // -------------------------------------------------------------------------
  // Handshake / issue decisions
  // -------------------------------------------------------------------------
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  always_comb begin
    inst_valid = (buf_state_q != BUF_EMPTY);
    pop        = inst_valid && inst_ready;
    // A response arriving in a redirect cycle belongs to the old stream.
    push       = inflight_q && !redirect_valid;
    // Entries held plus the one response still owed, minus what leaves now.
    // pop implies at least one entry, so this never underflows.
    occupancy  = {1'b0, buf_state_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Only issue when a slot is guaranteed for the response next cycle.
    issue      = !redirect_valid && (occupancy <= 3'd1);
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    buf_state_d   = buf_state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_valid) begin
      // Flush everything; a same-cycle pop is simply lost with the rest.
      buf_state_d = BUF_EMPTY;
      rd_ptr_d    = 1'b0;
      wr_ptr_d    = 1'b0;
      pc_d        = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      case ({push, pop})
        2'b10: begin
          case (buf_state_q)
            BUF_EMPTY: buf_state_d = BUF_ONE;
            BUF_ONE:   buf_state_d = BUF_FULL;
            default:   buf_state_d = buf_state_q;
          endcase
        end
        2'b01: begin
          case (buf_state_q)
            BUF_FULL: buf_state_d = BUF_ONE;
            BUF_ONE:  buf_state_d = BUF_EMPTY;
            default:  buf_state_d = buf_state_q;
          endcase
        end
        default: buf_state_d = buf_state_q;
      endcase

      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end

      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;  // wraps naturally at 2^32
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_state_q   <= BUF_EMPTY;
      pc_q          <= RESET_PC_ALIGNED;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      buf_state_q   <= buf_state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Buffer entries. Cleared on reset so the head outputs read zero then.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic ENTRY_IDX = 1'(gi);
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_inst_q[gi] <= 32'h0000_0000;
          entry_pc_q[gi]   <= 32'h0000_0000;
        end else if (push && (wr_ptr_q == ENTRY_IDX)) begin
          entry_inst_q[gi] <= imem_data;
          entry_pc_q[gi]   <= inflight_pc_q;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem_addr = pc_q;
  assign inst      = entry_inst_q[rd_ptr_q];
  assign inst_pc   = entry_pc_q[rd_ptr_q];

  // The issue rule must never let a response land in a full buffer.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (reset)
      !(push && (buf_state_q == BUF_FULL) && !pop)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;

  // DUT A: default reset PC
  logic        reset_a;
  logic [31:0] imem_addr_a;
  logic [31:0] imem_data_a;
  logic        redirect_valid_a;
  logic [31:0] redirect_pc_a;
  logic        inst_valid_a;
  logic [31:0] inst_a;
  logic [31:0] inst_pc_a;
  logic        ready_a;

  // DUT B: reset PC near the top of the address space
  logic        reset_b;
  logic [31:0] imem_addr_b;
  logic [31:0] imem_data_b;
  logic        redirect_valid_b;
  logic [31:0] redirect_pc_b;
  logic        inst_valid_b;
  logic [31:0] inst_b;
  logic [31:0] inst_pc_b;
  logic        ready_b;

  int vectors;
  int miscompares;

  logic [63:0] sb [$];  // {pc, inst}

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk            (clk),
    .reset          (reset_a),
    .imem_addr      (imem_addr_a),
    .imem_data      (imem_data_a),
    .redirect_valid (redirect_valid_a),
    .redirect_pc    (redirect_pc_a),
    .inst_valid     (inst_valid_a),
    .inst           (inst_a),
    .inst_pc        (inst_pc_a),
    .inst_ready     (ready_a)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk            (clk),
    .reset          (reset_b),
    .imem_addr      (imem_addr_b),
    .imem_data      (imem_data_b),
    .redirect_valid (redirect_valid_b),
    .redirect_pc    (redirect_pc_b),
    .inst_valid     (inst_valid_b),
    .inst           (inst_b),
    .inst_pc        (inst_pc_b),
    .inst_ready     (ready_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM models: registered read of word A000_0000 + (addr >> 2).
  always @(posedge clk) begin
    imem_data_a <= 32'hA000_0000 + (imem_addr_a >> 2);
    imem_data_b <= 32'hA000_0000 + (imem_addr_b >> 2);
  end

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'hA000_0000 + (addr >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] start_pc, input int n);
    logic [31:0] p;
    p = start_pc;
    for (int i = 0; i < n; i++) begin
      sb.push_back({p, word_at(p)});
      p = p + 32'd4;
    end
  endtask

  // Score any transfer happening at the coming edge, then advance one cycle.
  task automatic tick();
    logic [63:0] e;
    if (inst_valid_a && ready_a) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_underflow: observed pc %h, expected no transfer", inst_pc_a);
      end else begin
        e = sb.pop_front();
        check("sb_inst_pc", inst_pc_a, e[63:32]);
        check("sb_inst", inst_a, e[31:0]);
        $display("xfer pc=%h inst=%h", inst_pc_a, inst_a);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    vectors          = 0;
    miscompares      = 0;
    reset_a          = 1'b1;
    reset_b          = 1'b1;
    ready_a          = 1'b1;
    ready_b          = 1'b1;
    redirect_valid_a = 1'b0;
    redirect_pc_a    = 32'h0;
    redirect_valid_b = 1'b0;
    redirect_pc_b    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_valid", {31'b0, inst_valid_a}, 32'd0);
    check("rst_inst", inst_a, 32'h0);
    check("rst_inst_pc", inst_pc_a, 32'h0);
    check("rst_imem_addr", imem_addr_a, 32'h0);

    // Startup: this cycle is the first issue cycle (k=0)
    reset_a = 1'b0;
    push_exp(32'h0, 32);
    check("start_k0_valid", {31'b0, inst_valid_a}, 32'd0);
    check("start_k0_addr", imem_addr_a, 32'h0);
    tick();
    check("start_k1_valid", {31'b0, inst_valid_a}, 32'd0);
    tick();
    check("start_k2_valid", {31'b0, inst_valid_a}, 32'd1);
    check("start_k2_pc", inst_pc_a, 32'h0);
    tick();

    // Stall for 5 cycles starting on the 2nd valid cycle
    ready_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", {31'b0, inst_valid_a}, 32'd1);
      check("stall_inst", inst_a, 32'hA000_0001);
      check("stall_addr_hold", imem_addr_a, 32'h0000_000C);
      tick();
    end

    // Release: gap-free delivery of 4, 8, 12, 16, 20
    ready_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("release_valid", {31'b0, inst_valid_a}, 32'd1);
      tick();
    end

    // Fill the buffer, then redirect to 0x43 while it holds 2 entries
    ready_a = 1'b0;
    repeat (3) tick();
    redirect_valid_a = 1'b1;
    redirect_pc_a    = 32'h0000_0043;
    check("redir_full_valid", {31'b0, inst_valid_a}, 32'd1);
    tick();
    redirect_valid_a = 1'b0;
    ready_a          = 1'b1;
    sb.delete();
    push_exp(32'h0000_0040, 32);
    check("redir_r1_valid", {31'b0, inst_valid_a}, 32'd0);
    check("redir_r1_addr", imem_addr_a, 32'h0000_0040);
    tick();
    check("redir_r2_valid", {31'b0, inst_valid_a}, 32'd0);
    tick();
    check("redir_r3_valid", {31'b0, inst_valid_a}, 32'd1);
    check("redir_r3_pc", inst_pc_a, 32'h0000_0040);
    check("redir_r3_inst", inst_a, 32'hA000_0010);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("redir_stream_valid", {31'b0, inst_valid_a}, 32'd1);
    end

    // Redirect coinciding with a pop and an in-flight response
    redirect_valid_a = 1'b1;
    redirect_pc_a    = 32'h0000_0100;
    check("redir_pop_valid", {31'b0, inst_valid_a}, 32'd1);
    tick();
    redirect_valid_a = 1'b0;
    sb.delete();
    push_exp(32'h0000_0100, 32);
    check("redir2_r1_valid", {31'b0, inst_valid_a}, 32'd0);
    tick();
    check("redir2_r2_valid", {31'b0, inst_valid_a}, 32'd0);
    tick();
    check("redir2_r3_valid", {31'b0, inst_valid_a}, 32'd1);
    check("redir2_r3_pc", inst_pc_a, 32'h0000_0100);
    repeat (4) tick();

    // Mid-stream reset with the buffer full; redirect must be ignored
    ready_a = 1'b0;
    repeat (3) tick();
    check("prereset_valid", {31'b0, inst_valid_a}, 32'd1);
    reset_a          = 1'b1;
    redirect_valid_a = 1'b1;
    redirect_pc_a    = 32'h0000_0200;
    tick();
    reset_a          = 1'b0;
    redirect_valid_a = 1'b0;
    ready_a          = 1'b1;
    sb.delete();
    push_exp(32'h0, 32);
    check("mreset_k0_valid", {31'b0, inst_valid_a}, 32'd0);
    check("mreset_k0_inst", inst_a, 32'h0);
    check("mreset_k0_pc", inst_pc_a, 32'h0);
    check("mreset_k0_addr", imem_addr_a, 32'h0);
    tick();
    check("mreset_k1_valid", {31'b0, inst_valid_a}, 32'd0);
    tick();
    check("mreset_k2_valid", {31'b0, inst_valid_a}, 32'd1);
    check("mreset_k2_pc", inst_pc_a, 32'h0);
    repeat (4) tick();

    // DUT B: address wrap from RESET_PC = FFFF_FFF8
    ready_a = 1'b0;
    check("b_rst_valid", {31'b0, inst_valid_b}, 32'd0);
    check("b_rst_addr", imem_addr_b, 32'hFFFF_FFF8);
    reset_b = 1'b0;
    tick();
    check("b_k1_valid", {31'b0, inst_valid_b}, 32'd0);
    tick();
    exp_pc = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      check("b_valid", {31'b0, inst_valid_b}, 32'd1);
      check("b_inst_pc", inst_pc_b, exp_pc);
      check("b_inst", inst_b, word_at(exp_pc));
      $display("b xfer pc=%h inst=%h", inst_pc_b, inst_b);
      exp_pc = exp_pc + 32'd4;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
